i2c_bus_monitor: RTL and testbench

Sits directly downstream of the SCL/SDA synchronization-and-debounce stages in the I2C controller and consumes their clean, fastClock-domain bus levels. Detects START, repeated START and STOP conditions and SCL edges, and tracks bus-busy state. Assembles received bits MSB-first into bytes and reports each byte with its acknowledge bit and an address-byte flag. Only observes the bus; it never drives SCL or SDA.

---
 rtl/i2c_bus_monitor.sv | 138 +++++++++++++
 tb/tb_i2c_bus_monitor.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus observer: decodes START/STOP and SCL edges from clean bus levels,
// then assembles MSB-first bytes with their acknowledge bit and an address-byte flag.
module i2c_bus_monitor #(
   parameter int BYTE_BITS = 8
) (
   input  logic                 fastClock,
   input  logic                 resetN,
   input  logic                 sclDebounced,
   input  logic                 sdaDebounced,
   output logic                 startDetected,
   output logic                 stopDetected,
   output logic                 sclRise,
   output logic                 sclFall,
   output logic                 busBusy,
   output logic [BYTE_BITS-1:0] byteData,
   output logic                 byteValid,
   output logic                 ackBit,
   output logic                 byteIsAddress,
   output logic [1:0]           dbgState
);

   localparam int CW = $clog2(BYTE_BITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ADDRESS = 2'd1,
      ST_DATA    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         bit_count_q, bit_count_d;
   logic [BYTE_BITS-1:0]  shift_q, shift_d;
   logic                  scl_prev_q, scl_prev_d;
   logic                  sda_prev_q, sda_prev_d;
   logic                  start_q, start_d;
   logic                  stop_q, stop_d;
   logic                  rise_q, rise_d;
   logic                  fall_q, fall_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
   logic [BYTE_BITS-1:0]  data_q, data_d;
   logic                  ack_q, ack_d;
   logic                  is_addr_q, is_addr_d;
   logic                  start_cond, stop_cond;

   // START/STOP need SCL high on both samples, so an SDA change coincident with an
   // SCL edge is never mistaken for a bus condition.
   always_comb begin
      start_cond  = scl_prev_q & sclDebounced & sda_prev_q & ~sdaDebounced;
      stop_cond   = scl_prev_q & sclDebounced & ~sda_prev_q & sdaDebounced;

      state_d     = state_q;
      bit_count_d = bit_count_q;
      shift_d     = shift_q;
      busy_d      = busy_q;
      valid_d     = 1'b0;
      data_d      = data_q;
      ack_d       = ack_q;
      is_addr_d   = is_addr_q;
      start_d     = start_cond;
      stop_d      = stop_cond;
      rise_d      = ~scl_prev_q & sclDebounced;
      fall_d      = scl_prev_q & ~sclDebounced;
      scl_prev_d  = sclDebounced;
      sda_prev_d  = sdaDebounced;

      if (start_cond) begin
         state_d     = ST_ADDRESS;
         bit_count_d = '0;
         shift_d     = '0;
         busy_d      = 1'b1;
      end else if (stop_cond) begin
         state_d     = ST_IDLE;
         bit_count_d = '0;
         shift_d     = '0;
         busy_d      = 1'b0;
      end else if (rise_d && (state_q != ST_IDLE)) begin
         if (bit_count_q == CW'(BYTE_BITS)) begin
            // Ninth clock: the shift register already holds the full byte.
            ack_d       = sdaDebounced;
            data_d      = shift_q;
            is_addr_d   = (state_q == ST_ADDRESS);
            valid_d     = 1'b1;
            bit_count_d = '0;
            state_d     = ST_DATA;
         end else begin
            shift_d     = {shift_q[BYTE_BITS-2:0], sdaDebounced};
            bit_count_d = bit_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge fastClock or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         bit_count_q <= '0;
         shift_q     <= '0;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         ack_q       <= 1'b0;
         is_addr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_count_q <= bit_count_d;
         shift_q     <= shift_d;
         scl_prev_q  <= scl_prev_d;
         sda_prev_q  <= sda_prev_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         ack_q       <= ack_d;
         is_addr_q   <= is_addr_d;
      end
   end

   assign startDetected = start_q;
   assign stopDetected  = stop_q;
   assign sclRise       = rise_q;
   assign sclFall       = fall_q;
   assign busBusy       = busy_q;
   assign byteData      = data_q;
   assign byteValid     = valid_q;
   assign ackBit        = ack_q;
   assign byteIsAddress = is_addr_q;
   assign dbgState      = state_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: per-cycle reference model on random bus traffic,
// an edge/condition table, and directed byte-level sequences.
module tb_i2c_bus_monitor;

   localparam int BB = 8;

   logic          fastClock;
   logic          rst_n;
   logic          scl_in, sda_in;
   logic          startDetected, stopDetected, sclRise, sclFall, busBusy;
   logic [BB-1:0] byteData;
   logic          byteValid, ackBit, byteIsAddress;
   logic [1:0]    dbgState;

   int n_vec = 0;
   int n_bad = 0;

   i2c_bus_monitor #(.BYTE_BITS(BB)) dut (
      .fastClock     (fastClock),
      .resetN        (rst_n),
      .sclDebounced  (scl_in),
      .sdaDebounced  (sda_in),
      .startDetected (startDetected),
      .stopDetected  (stopDetected),
      .sclRise       (sclRise),
      .sclFall       (sclFall),
      .busBusy       (busBusy),
      .byteData      (byteData),
      .byteValid     (byteValid),
      .ackBit        (ackBit),
      .byteIsAddress (byteIsAddress),
      .dbgState      (dbgState)
   );

   // ---------------- clock / reset ----------------
   initial fastClock = 1'b0;
   always #5 fastClock = ~fastClock;

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic          m_start = 0, m_stop = 0, m_rise = 0, m_fall = 0, m_busy = 0, m_valid = 0;
   logic          m_ack = 0, m_addr = 0;
   logic [BB-1:0] m_data = '0;
   logic          m_ps = 1, m_pd = 1, m_in_frame = 0, m_first = 0;
   logic          m_bits[$];

   always @(posedge fastClock) begin
      if (!rst_n) begin
         {m_start, m_stop, m_rise, m_fall, m_busy, m_valid, m_ack, m_addr} = '0;
         m_data = '0;
         m_ps = 1; m_pd = 1; m_in_frame = 0; m_first = 0;
         m_bits.delete();
      end else begin
         m_start = m_ps && scl_in && m_pd && !sda_in;
         m_stop  = m_ps && scl_in && !m_pd && sda_in;
         m_rise  = !m_ps && scl_in;
         m_fall  = m_ps && !scl_in;
         m_valid = 0;
         if (m_start) begin
            m_in_frame = 1; m_first = 1; m_bits.delete();
         end else if (m_stop) begin
            m_in_frame = 0; m_first = 0; m_bits.delete();
         end else if (m_rise && m_in_frame) begin
            m_bits.push_back(sda_in);
            if (m_bits.size() == BB + 1) begin
               m_data = '0;
               for (int i = 0; i < BB; i++)
                  if (m_bits[i]) m_data = m_data | BB'(1 << (BB - 1 - i));
               m_ack   = m_bits[BB];
               m_addr  = m_first;
               m_first = 0;
               m_valid = 1;
               m_bits.delete();
            end
         end
         m_busy = m_in_frame;
         m_ps = scl_in; m_pd = sda_in;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [BB+7:0] exp_q[$];
   int cnt_start, cnt_stop, cnt_rise, cnt_fall, cnt_valid, cnt_busy_low;
   logic [BB-1:0] cap_data;
   logic          cap_ack, cap_addr;

   always @(negedge fastClock) begin
      logic [BB+7:0] act_v, exp_v;
      act_v = {startDetected, stopDetected, sclRise, sclFall, busBusy, byteValid,
               ackBit, byteIsAddress, byteData};
      if (!rst_n) exp_v = '0;
      else exp_v = {m_start, m_stop, m_rise, m_fall, m_busy, m_valid, m_ack, m_addr, m_data};
      exp_q.push_back(exp_v);
      chk("cycle_model", 64'(act_v), 64'(exp_q.pop_front()));
      if (rst_n) begin
         cnt_start += int'(startDetected);
         cnt_stop  += int'(stopDetected);
         cnt_rise  += int'(sclRise);
         cnt_fall  += int'(sclFall);
         cnt_valid += int'(byteValid);
         if (!busBusy) cnt_busy_low++;
         if (byteValid) begin
            cap_data = byteData; cap_ack = ackBit; cap_addr = byteIsAddress;
         end
      end
   end

   task automatic clear_counts();
      cnt_start = 0; cnt_stop = 0; cnt_rise = 0; cnt_fall = 0;
      cnt_valid = 0; cnt_busy_low = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic s, input logic d);
      @(negedge fastClock);
      scl_in = s;
      sda_in = d;
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge fastClock);
   endtask

   task automatic settle();
      hold(3);
      #1;
   endtask

   task automatic send_bit(input logic b);
      drive(1'b0, b);
      drive(1'b1, b);
      drive(1'b0, b);
   endtask

   task automatic send_byte(input logic [BB-1:0] data, input logic ack);
      for (int i = BB - 1; i >= 0; i--) send_bit(data[i]);
      send_bit(ack);
   endtask

   task automatic bus_start();
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
   endtask

   task automatic bus_stop();
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
   endtask

   task automatic rep_start();
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
   endtask

   // ---------------- edge/condition table ----------------
   typedef struct {
      logic scl, sda;
      logic start, stop, rise, fall, busy;
   } vec_t;

   function automatic vec_t mk(input logic scl, sda, start, stop, rise, fall, busy);
      vec_t v;
      v.scl = scl; v.sda = sda; v.start = start; v.stop = stop;
      v.rise = rise; v.fall = fall; v.busy = busy;
      return v;
   endfunction

   vec_t tbl[14];

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; scl_in = 1'b1; sda_in = 1'b1;
      clear_counts();
      cap_data = '0; cap_ack = 0; cap_addr = 0;

      //            scl sda st sp ri fa busy
      tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 0, 0, 0, 1, 0);
      tbl[2]  = mk(1, 1, 0, 0, 1, 0, 0);
      tbl[3]  = mk(1, 0, 1, 0, 0, 0, 1);
      tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1);
      tbl[5]  = mk(0, 0, 0, 0, 0, 1, 1);
      tbl[6]  = mk(1, 0, 0, 0, 1, 0, 1);
      tbl[7]  = mk(1, 1, 0, 1, 0, 0, 0);
      tbl[8]  = mk(1, 1, 0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 0, 1, 0, 0, 0, 1);
      tbl[10] = mk(0, 1, 0, 0, 0, 1, 1);
      tbl[11] = mk(1, 0, 0, 0, 1, 0, 1);
      tbl[12] = mk(1, 1, 0, 1, 0, 0, 0);
      tbl[13] = mk(1, 1, 0, 0, 0, 0, 0);

      // reset state and quiet idle bus
      hold(3);
      @(negedge fastClock);
      rst_n = 1'b1;
      #1;
      chk("rst_start", 64'(startDetected), 0);
      chk("rst_stop", 64'(stopDetected), 0);
      chk("rst_rise_fall", 64'({sclRise, sclFall}), 0);
      chk("rst_busy", 64'(busBusy), 0);
      chk("rst_byte", 64'({byteValid, ackBit, byteIsAddress, byteData}), 0);
      chk("rst_state", 64'(dbgState), 0);
      clear_counts();
      hold(20);
      #1;
      chk("idle_no_pulses", 64'(cnt_start + cnt_stop + cnt_rise + cnt_fall + cnt_valid), 0);

      // table of single level changes
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].scl, tbl[i].sda);
         @(negedge fastClock);
         #1;
         chk($sformatf("tbl%0d", i),
             64'({startDetected, stopDetected, sclRise, sclFall, busBusy, byteValid}),
             64'({tbl[i].start, tbl[i].stop, tbl[i].rise, tbl[i].fall, tbl[i].busy, 1'b0}));
      end

      // address 0xA4 + ACK
      clear_counts();
      bus_start();
      send_byte(8'hA4, 1'b0);
      settle();
      chk("addr_start_cnt", 64'(cnt_start), 1);
      chk("addr_valid_cnt", 64'(cnt_valid), 1);
      chk("addr_fields", 64'({cap_data, cap_ack, cap_addr}), 64'({8'hA4, 1'b0, 1'b1}));
      chk("addr_busy", 64'(busBusy), 1);

      // data 0x5B + NACK, then STOP
      clear_counts();
      send_byte(8'h5B, 1'b1);
      bus_stop();
      settle();
      chk("data_valid_cnt", 64'(cnt_valid), 1);
      chk("data_fields", 64'({cap_data, cap_ack, cap_addr}), 64'({8'h5B, 1'b1, 1'b0}));
      chk("data_stop_cnt", 64'(cnt_stop), 1);
      chk("data_busy", 64'(busBusy), 0);
      chk("data_state_idle", 64'(dbgState), 0);
      chk("data_held", 64'({byteData, ackBit, byteIsAddress}), 64'({8'h5B, 1'b1, 1'b0}));

      // partial byte then repeated START
      clear_counts();
      bus_start();
      cnt_busy_low = 0;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rep_start();
      send_byte(8'h3C, 1'b0);
      settle();
      chk("rs_start_cnt", 64'(cnt_start), 2);
      chk("rs_valid_cnt", 64'(cnt_valid), 1);
      chk("rs_fields", 64'({cap_data, cap_ack, cap_addr}), 64'({8'h3C, 1'b0, 1'b1}));
      chk("rs_busy_held", 64'(cnt_busy_low), 0);
      bus_stop();

      // SCL toggling in IDLE, then simultaneous SCL/SDA changes
      settle();
      clear_counts();
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1);
         drive(1'b1, 1'b1);
      end
      settle();
      chk("idle_rise_cnt", 64'(cnt_rise), 9);
      chk("idle_fall_cnt", 64'(cnt_fall), 9);
      drive(1'b0, 1'b0);
      settle();
      drive(1'b1, 1'b1);
      settle();
      chk("simul_no_cond", 64'({cnt_start, cnt_stop}), 0);
      chk("simul_edges", 64'({cnt_rise, cnt_fall}), 64'({32'd10, 32'd10}));
      chk("idle_no_valid", 64'(cnt_valid), 0);

      // asynchronous reset mid-byte, then traffic without START
      bus_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      @(negedge fastClock);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_outputs",
          64'({startDetected, stopDetected, sclRise, sclFall, busBusy, byteValid,
               ackBit, byteIsAddress, byteData}), 0);
      hold(2);
      @(negedge fastClock);
      rst_n = 1'b1;
      clear_counts();
      send_byte(8'hFF, 1'b0);
      send_byte(8'h00, 1'b1);
      settle();
      chk("post_rst_no_valid", 64'(cnt_valid), 0);
      chk("post_rst_busy", 64'({cnt_start, 31'd0, busBusy}), 0);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      bus_start();
      send_byte(8'h96, 1'b1);
      settle();
      chk("post_rst_byte", 64'({cnt_valid[7:0], cap_data, cap_ack, cap_addr}),
          64'({8'd1, 8'h96, 1'b1, 1'b1}));
      bus_stop();

      // randomized bus traffic against the model
      for (int it = 0; it < 300; it++) begin
         int op;
         op = $urandom_range(0, 20);
         if (op < 3) begin
            drive(1'b0, sda_in);
            drive(1'b0, 1'b1);
            drive(1'b1, 1'b1);
            drive(1'b1, 1'b0);
            drive(1'b0, 1'b0);
         end else if (op < 9) begin
            send_byte(BB'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         end else if (op < 11) begin
            int nb;
            nb = $urandom_range(1, BB);
            for (int k = 0; k < nb; k++) send_bit(1'($urandom_range(0, 1)));
         end else if (op < 13) begin
            drive(1'b0, sda_in);
            drive(1'b0, 1'b0);
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b1);
         end else if (op < 17) begin
            int nc;
            nc = $urandom_range(1, 6);
            for (int k = 0; k < nc; k++)
               drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if (op < 20) begin
            hold($urandom_range(0, 3));
         end else begin
            @(negedge fastClock);
            #($urandom_range(1, 4));
            rst_n = 1'b0;
            hold(1);
            @(negedge fastClock);
            rst_n = 1'b1;
         end
      end

      settle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
